// File: rtl/spike_encoder.sv
// spike_encoder: rate-coded spike source; define SPIKE_ENCODER_POISSON_EN for the LFSR encoder
module spike_encoder #(
  parameter int          NUM_INPUTS  = 1,
  parameter int          PIXEL_WIDTH = 8,
  parameter int          NUM_STEPS   = 100,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [NUM_INPUTS*PIXEL_WIDTH-1:0] pixel_in,
  output logic                              busy,
  output logic                              done,
  output logic [NUM_INPUTS-1:0]             spike_out,
  output logic [$clog2(NUM_STEPS+1)-1:0]    step_cnt
);
  localparam int SW = $clog2(NUM_STEPS+1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [NUM_INPUTS-1:0] spike_nxt;
  logic accept, last;
  assign accept = (state == IDLE) && start;
  assign last   = step_cnt == SW'(NUM_STEPS-1);
  assign busy   = state == RUN;
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ch
    logic [PIXEL_WIDTH-1:0] pix;
`ifdef SPIKE_ENCODER_POISSON_EN
    localparam logic [15:0] SEED = LFSR_SEED ^ 16'(i+1);
    localparam logic [15:0] SEED_NZ = (SEED == 16'h0) ? 16'h1 : SEED;
    logic [15:0] lfsr, lfsr_nxt;
    assign lfsr_nxt     = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
    assign spike_nxt[i] = lfsr[PIXEL_WIDTH-1:0] < pix;
    // per-channel pixel latch and LFSR, reloaded on accept and stepped every timestep
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pix  <= '0;
        lfsr <= SEED_NZ;
      end else if (accept) begin
        pix  <= pixel_in[i*PIXEL_WIDTH +: PIXEL_WIDTH];
        lfsr <= SEED_NZ;
      end else if (state == RUN) begin
        lfsr <= lfsr_nxt;
      end
    end
`else
    logic [PIXEL_WIDTH-1:0] acc;
    logic [PIXEL_WIDTH:0]   sum;
    assign sum          = {1'b0, acc} + {1'b0, pix};
    assign spike_nxt[i] = sum[PIXEL_WIDTH];
    // per-channel pixel latch and phase accumulator; the carry out is the spike
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pix <= '0;
        acc <= '0;
      end else if (accept) begin
        pix <= pixel_in[i*PIXEL_WIDTH +: PIXEL_WIDTH];
        acc <= '0;
      end else if (state == RUN) begin
        acc <= sum[PIXEL_WIDTH-1:0];
      end
    end
`endif
  end
  // run framing: one timestep per clock in RUN, done marks the final timestep
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      done      <= 1'b0;
      spike_out <= '0;
      step_cnt  <= '0;
    end else if (state == IDLE) begin
      done      <= 1'b0;
      spike_out <= '0;
      if (start) begin
        state    <= RUN;
        step_cnt <= '0;
      end
    end else begin
      spike_out <= spike_nxt;
      step_cnt  <= step_cnt + SW'(1);
      done      <= last;
      if (last) state <= IDLE;
    end
  end
endmodule
